// File: rtl/ahb_resp_mux_if.sv
// AHB-Lite response-mux bus bundle: decoder select, address-phase HTRANS,
// per-slave responses in, muxed master response out.
interface ahb_resp_mux_if #(
  parameter int NUM_S = 4,
  parameter int DW    = 32
);
  logic [NUM_S-1:0]    H_sel_i;
  logic [1:0]          H_trans_i;
  logic [NUM_S-1:0]    H_ready_s_i;
  logic [NUM_S-1:0]    H_resp_s_i;
  logic [NUM_S*DW-1:0] H_rdata_s_i;
  logic                H_ready_o;
  logic                H_resp_o;
  logic [DW-1:0]       H_rdata_o;
  logic [NUM_S-1:0]    H_dsel_o;

  // Mux side of the bundle.
  modport slave (
    input  H_sel_i, H_trans_i, H_ready_s_i, H_resp_s_i, H_rdata_s_i,
    output H_ready_o, H_resp_o, H_rdata_o, H_dsel_o
  );

  // Fabric/master side of the bundle.
  modport master (
    output H_sel_i, H_trans_i, H_ready_s_i, H_resp_s_i, H_rdata_s_i,
    input  H_ready_o, H_resp_o, H_rdata_o, H_dsel_o
  );
endinterface

// File: rtl/ahb_resp_mux.sv
// AHB-Lite slave-to-master response multiplexer with registered data-phase
// select and a built-in default slave answering unmapped transfers.
module ahb_resp_mux #(
  parameter int NUM_S   = 4,
  parameter int DW      = 32,
  parameter int DEF_ERR = 1
) (
  input  logic               H_clk,
  input  logic               H_rst,
  ahb_resp_mux_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t           state, state_nxt;
  logic [NUM_S-1:0] dsel, dsel_nxt;
  logic [NUM_S-1:0] sel_pri;
  logic             unmapped_active;
  logic             hready;
  logic             hresp;
  logic [DW-1:0]    hrdata;

  // Isolate the lowest set bit so a multi-hot select resolves to the lowest index.
  assign sel_pri = bus.H_sel_i & (~bus.H_sel_i + NUM_S'(1));

  assign unmapped_active = (DEF_ERR != 0) && (bus.H_sel_i == '0) && bus.H_trans_i[1];

  always_ff @(posedge H_clk) begin
    if (H_rst) begin
      state <= S_IDLE;
      dsel  <= '0;
    end else begin
      state <= state_nxt;
      dsel  <= dsel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dsel_nxt  = dsel;
    case (state)
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        if (hready) begin
          state_nxt = unmapped_active ? S_ERR1 : S_IDLE;
          dsel_nxt  = sel_pri;
        end
      end
    endcase
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    for (int unsigned k = 0; k < NUM_S; k++) begin
      if (dsel[k]) begin
        hready = bus.H_ready_s_i[k];
        hresp  = bus.H_resp_s_i[k];
        hrdata = bus.H_rdata_s_i[k*DW +: DW];
      end
    end
    // The default slave's two-cycle ERROR overrides any slave path.
    case (state)
      S_ERR1: begin
        hready = 1'b0;
        hresp  = 1'b1;
        hrdata = '0;
      end
      S_ERR2: begin
        hready = 1'b1;
        hresp  = 1'b1;
        hrdata = '0;
      end
      default: ;
    endcase
  end

  assign bus.H_ready_o = hready;
  assign bus.H_resp_o  = hresp;
  assign bus.H_rdata_o = hrdata;
  assign bus.H_dsel_o  = dsel;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed scoreboard bench for ahb_resp_mux (DEF_ERR=1 main DUT, DEF_ERR=0 companion).
module tb_ahb_resp_mux;

  logic        H_clk = 1'b0;
  logic        H_rst = 1'b1;
  logic [31:0] rd [4];

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string       tag;
    logic [37:0] v;
  } exp_t;

  exp_t sb[$];

  ahb_resp_mux_if #(.NUM_S(4), .DW(32)) bus0 ();
  ahb_resp_mux_if #(.NUM_S(4), .DW(32)) bus1 ();

  ahb_resp_mux #(.NUM_S(4), .DW(32), .DEF_ERR(1)) dut0 (
    .H_clk (H_clk),
    .H_rst (H_rst),
    .bus   (bus0)
  );

  ahb_resp_mux #(.NUM_S(4), .DW(32), .DEF_ERR(0)) dut1 (
    .H_clk (H_clk),
    .H_rst (H_rst),
    .bus   (bus1)
  );

  always #5 H_clk = ~H_clk;

  assign bus0.H_rdata_s_i = {rd[3], rd[2], rd[1], rd[0]};
  assign bus1.H_sel_i     = bus0.H_sel_i;
  assign bus1.H_trans_i   = bus0.H_trans_i;
  assign bus1.H_ready_s_i = bus0.H_ready_s_i;
  assign bus1.H_resp_s_i  = bus0.H_resp_s_i;
  assign bus1.H_rdata_s_i = bus0.H_rdata_s_i;

  // One bus cycle: drive at negedge, push the expected main-DUT outputs, compare 1ns later.
  task automatic cyc(input string tag, input logic r, input logic [3:0] sel,
                     input logic [1:0] tr, input logic [3:0] rdy, input logic [3:0] rsp,
                     input logic e_rdy, input logic e_rsp, input logic [31:0] e_rd,
                     input logic [3:0] e_ds);
    exp_t        e;
    logic [37:0] obs;
    @(negedge H_clk);
    H_rst            = r;
    bus0.H_sel_i     = sel;
    bus0.H_trans_i   = tr;
    bus0.H_ready_s_i = rdy;
    bus0.H_resp_s_i  = rsp;
    sb.push_back('{tag, {e_rdy, e_rsp, e_rd, e_ds}});
    #1;
    e   = sb.pop_front();
    obs = {bus0.H_ready_o, bus0.H_resp_o, bus0.H_rdata_o, bus0.H_dsel_o};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  // Companion DEF_ERR=0 check at the current sample point.
  task automatic chk1(input string tag, input logic e_rdy, input logic e_rsp);
    exp_t        e;
    logic [37:0] obs;
    sb.push_back('{tag, {e_rdy, e_rsp, 32'h0, 4'h0}});
    e   = sb.pop_front();
    obs = {bus1.H_ready_o, bus1.H_resp_o, bus1.H_rdata_o, bus1.H_dsel_o};
    total++;
    assert (obs === e.v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  initial begin
    rd[0] = 32'hFFFF_FFFF;
    rd[1] = 32'h1111_0001;
    rd[2] = 32'hCAFE_0002;
    rd[3] = 32'h3333_0003;
    bus0.H_sel_i     = '0;
    bus0.H_trans_i   = 2'b00;
    bus0.H_ready_s_i = 4'b1011;
    bus0.H_resp_s_i  = '0;

    // Reset with slave 2 stalled
    cyc("rst_a", 1, 4'b0000, 2'b00, 4'b1011, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("rst_b", 1, 4'b0000, 2'b00, 4'b1011, 4'b0000, 1, 0, 32'h0, 4'b0000);

    // Zero-wait read from slave 2, slave 0 stalled but unselected
    cyc("zw_addr", 0, 4'b0100, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("zw_data", 0, 4'b0000, 2'b00, 4'b1110, 4'b0000, 1, 0, 32'hCAFE_0002, 4'b0100);

    // Slave 1 with three wait states; new address presented during stall
    cyc("ws_addr",  0, 4'b0010, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("ws_st1",   0, 4'b1000, 2'b10, 4'b1101, 4'b0000, 0, 0, 32'h1111_0001, 4'b0010);
    cyc("ws_st2",   0, 4'b1000, 2'b10, 4'b1101, 4'b0000, 0, 0, 32'h1111_0001, 4'b0010);
    cyc("ws_st3",   0, 4'b1000, 2'b10, 4'b1101, 4'b0000, 0, 0, 32'h1111_0001, 4'b0010);
    cyc("ws_done",  0, 4'b1000, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h1111_0001, 4'b0010);
    cyc("ws_next",  0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 32'h3333_0003, 4'b1000);

    // Unmapped NONSEQ: ERR1 then ERR2; companion stays zero-wait OKAY
    cyc("um_addr",  0, 4'b0000, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("um_err1",  0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 0, 1, 32'h0, 4'b0000);
    chk1("um_err1_noerr", 1, 0);
    cyc("um_err2",  0, 4'b0000, 2'b01, 4'b1111, 4'b0000, 1, 1, 32'h0, 4'b0000);
    chk1("um_err2_noerr", 1, 0);
    // BUSY unmapped was presented on the ERR2 cycle: no error follows
    cyc("um_busy",  0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("um_idle",  0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);

    // Unmapped error followed by address captured on the ERR2 edge
    cyc("um2_addr", 0, 4'b0000, 2'b11, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("um2_err1", 0, 4'b0001, 2'b10, 4'b1111, 4'b0000, 0, 1, 32'h0, 4'b0000);
    cyc("um2_err2", 0, 4'b0001, 2'b10, 4'b1111, 4'b0000, 1, 1, 32'h0, 4'b0000);
    cyc("um2_next", 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 32'hFFFF_FFFF, 4'b0001);

    // Multi-hot select resolves to slave 1; its ERROR passes through
    cyc("mh_addr",  0, 4'b1010, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("mh_err1",  0, 4'b0000, 2'b00, 4'b1101, 4'b0010, 0, 1, 32'h1111_0001, 4'b0010);
    cyc("mh_err2",  0, 4'b0000, 2'b00, 4'b1111, 4'b0010, 1, 1, 32'h1111_0001, 4'b0010);
    cyc("mh_after", 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);

    // Reset during ERR1
    cyc("re_addr",  0, 4'b0000, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("re_err1",  1, 4'b0000, 2'b10, 4'b1111, 4'b0000, 0, 1, 32'h0, 4'b0000);
    cyc("re_after", 0, 4'b0000, 2'b00, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);

    // Reset during a slave wait state
    cyc("rw_addr",  0, 4'b0100, 2'b10, 4'b1111, 4'b0000, 1, 0, 32'h0, 4'b0000);
    cyc("rw_wait",  1, 4'b0000, 2'b00, 4'b1011, 4'b0000, 0, 0, 32'hCAFE_0002, 4'b0100);
    cyc("rw_after", 0, 4'b0000, 2'b00, 4'b1011, 4'b0000, 1, 0, 32'h0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_resp_mux.md
# ahb_resp_mux

Parametrised AHB-Lite slave-to-master response multiplexer for the bus fabric, sitting between the N slave response ports and the single master (RISC-V core) data-phase inputs. Generalises the fixed two-slave AND/OR combine: it registers the decoder's address-phase select into a data-phase select, steers HREADY/HRESP/HRDATA from the one selected slave, and contains a built-in default slave that returns the two-cycle AHB ERROR response for unmapped active transfers.

## Interface
Parameters:
- NUM_S, 4, number of slave ports (2..16)
- DW, 32, read-data width
- DEF_ERR, 1, 1 = unmapped NONSEQ/SEQ gets ERROR; 0 = unmapped gets zero-wait OKAY

Ports:
- H_clk  in  1  bus clock; all state updates on rising edge
- H_rst  in  1  reset, synchronous, active-high
- H_sel_i  in  NUM_S  address-phase slave select from decoder, nominally one-hot; all-zero = unmapped
- H_trans_i  in  2  address-phase HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- H_ready_s_i  in  NUM_S  per-slave HREADYOUT, bit k = slave k
- H_resp_s_i  in  NUM_S  per-slave HRESP, bit k = slave k
- H_rdata_s_i  in  NUM_S*DW  per-slave HRDATA, slave k at [k*DW +: DW]
- H_ready_o  out  1  HREADY to master and fed back to all slaves
- H_resp_o  out  1  HRESP to master
- H_rdata_o  out  DW  HRDATA to master
- H_dsel_o  out  NUM_S  registered data-phase select (debug/observability)

## Operation
- State: dsel (NUM_S bits, one-hot or zero); default-slave FSM {IDLE, ERR1, ERR2}.
- Address-phase capture: only on edges where H_ready_o=1. dsel <= lowest-index set bit of H_sel_i (multi-hot resolved by priority, lowest index wins); H_ready_o=0 holds dsel and FSM.
- FSM transitions:
  - IDLE/ERR2 -> ERR1 when H_ready_o=1, H_sel_i=0, H_trans_i[1]=1, DEF_ERR=1.
  - IDLE/ERR2 -> IDLE otherwise (when H_ready_o=1).
  - ERR1 -> ERR2 unconditionally.
- Output select, priority order:
  - ERR1: H_ready_o=0, H_resp_o=1, H_rdata_o=0.
  - ERR2: H_ready_o=1, H_resp_o=1, H_rdata_o=0.
  - dsel bit k set: H_ready_o=H_ready_s_i[k], H_resp_o=H_resp_s_i[k], H_rdata_o=slave k data.
  - dsel=0 (idle, unmapped IDLE/BUSY, or DEF_ERR=0): H_ready_o=1, H_resp_o=0, H_rdata_o=0.
- Unselected slaves' ready/resp/rdata are ignored entirely (no AND/OR combining); a stalled unselected slave never stalls the bus.
- Slave ERROR responses pass through unmodified; mux does not generate or alter them.
- IDLE/BUSY to a mapped slave still selects that slave; slave supplies the (OKAY) response.
- Reset: dsel=0, FSM=IDLE → H_ready_o=1, H_resp_o=0, H_rdata_o=0, H_dsel_o=0 from the cycle after the reset edge. Reset asserted mid-transfer (including during a wait state or ERR1) wins over hold and clears state at that edge.

## Timing
- Select latency: exactly 1 cycle; address phase in cycle n → data phase muxed from slave in cycle n+1 onward, until H_ready_o=1.
- Data path: purely combinational from H_*_s_i to outputs within the data phase; zero added wait states.
- Wait states: each H_ready_s_i[k]=0 cycle extends the data phase by one cycle; dsel stable throughout.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1 then ERR2); next address captured on the ERR2 edge.
- Back-to-back: slave switch on consecutive transfers has no bubble.

## Test plan
- Reset: assert H_rst 2 cycles with slave 2 driving ready=0 → outputs ready=1, resp=0, rdata=0, dsel=0 after reset edge.
- Zero-wait read: NONSEQ, H_sel_i=4'b0100; next cycle slave 2 drives ready=1, rdata=0xCAFE_0002, slave 0 drives 0xFFFF_FFFF, ready=0 → H_rdata_o=0xCAFE_0002, H_ready_o=1.
- Wait states: select slave 1, slave 1 ready=0 for 3 cycles, address H_sel_i changed to 4'b1000 during stall → H_ready_o low 3 cycles, dsel stays 4'b0010, then captures 4'b1000.
- Unmapped: NONSEQ with H_sel_i=0 → next cycle ready=0/resp=1, then ready=1/resp=1, rdata=0; IDLE with H_sel_i=0 → ready=1/resp=0; with DEF_ERR=0 NONSEQ unmapped → ready=1/resp=0.
- Multi-hot and error pass-through: H_sel_i=4'b1010 → dsel=4'b0010; slave 1 returns resp=1 two cycles (ready 0 then 1) → passed verbatim.
- Reset in ERR1: assert H_rst during ERR1 → next cycle IDLE, ready=1, resp=0.
